// File: rtl/rtc_bus_responder.sv
// Responder side of the multiplexed AD/cs/rd/wr RTC bus: BCD clock, calendar and
// countdown timer advanced once per prescaled second.
module rtc_bus_responder #(
   parameter int unsigned TICKS_PER_SEC = 100000000,
   parameter int unsigned MIN_STROBE    = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       cs,
   input  logic       ad,
   input  logic       wr,
   input  logic       rd,
   input  logic [7:0] ADin,
   output logic [7:0] ADout,
   output logic       ADoe,
   output logic       irq_n,
   output logic       tick
);
   localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PW-1:0] PMAX = PW'(TICKS_PER_SEC - 1);
   localparam logic [7:0] MIN_CNT = 8'(MIN_STROBE);

   typedef enum logic [1:0] {IDLE, ADDR_LOW, WDATA_LOW, RDATA} state_t;

   state_t state;
   logic s_cs, s_ad, s_wr, s_rd;
   logic [7:0] s_din, cnt, addr, lat, rd_val;
   logic wr_go, tick_now, tick_defer, adv;
   logic [PW-1:0] pre;
   logic [7:0] ctrl, status, sec, min, hr, day, mon, yr, tsec, tmin, thr;
   logic [7:0] n_sec, n_min, n_hr, n_day, n_mon, n_yr, n_tsec, n_tmin, n_thr, h_inc;
   logic c_h, c_d, c_mo, c_y, t_expire;

   function automatic logic [7:0] inc_bcd(input logic [7:0] v);
      return (v[3:0] == 4'h9) ? {v[7:4] + 4'h1, 4'h0} : v + 8'h01;
   endfunction

   function automatic logic [7:0] dec_bcd(input logic [7:0] v);
      return (v[3:0] == 4'h0) ? {v[7:4] - 4'h1, 4'h9} : v - 8'h01;
   endfunction

   // A BCD year is a multiple of 4 when an even tens digit pairs with 0/4/8 or an odd one with 2/6.
   function automatic logic [7:0] month_days(input logic [7:0] m, input logic [7:0] y);
      logic leap;
      leap = y[4] ? (y[3:0] == 4'h2 || y[3:0] == 4'h6)
                  : (y[3:0] == 4'h0 || y[3:0] == 4'h4 || y[3:0] == 4'h8);
      case (m)
         8'h02:                      return leap ? 8'h29 : 8'h28;
         8'h04, 8'h06, 8'h09, 8'h11: return 8'h30;
         default:                    return 8'h31;
      endcase
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_cs <= 1'b1; s_ad <= 1'b0; s_wr <= 1'b1; s_rd <= 1'b1; s_din <= '0;
      end else begin
         s_cs <= cs; s_ad <= ad; s_wr <= wr; s_rd <= rd; s_din <= ADin;
      end
   end

   always_comb begin
      rd_val = '0;
      case (addr)
         8'h00: rd_val = ctrl;
         8'h01: rd_val = status;
         8'h21: rd_val = sec;
         8'h22: rd_val = min;
         8'h23: rd_val = hr;
         8'h24: rd_val = day;
         8'h25: rd_val = mon;
         8'h26: rd_val = yr;
         8'h41: rd_val = tsec;
         8'h42: rd_val = tmin;
         8'h43: rd_val = thr;
         default: rd_val = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE; cnt <= '0; addr <= '0; lat <= '0; wr_go <= 1'b0;
         ADoe <= 1'b0; ADout <= '0;
      end else begin
         wr_go <= 1'b0;
         case (state)
            IDLE: begin
               ADoe  <= 1'b0;
               ADout <= '0;
               if (!s_cs && !s_wr && s_rd) begin
                  state <= s_ad ? WDATA_LOW : ADDR_LOW;
                  cnt   <= 8'd1;
                  lat   <= s_din;
               end else if (!s_cs && !s_rd && s_wr && s_ad) begin
                  state <= RDATA;
                  ADoe  <= 1'b1;
                  ADout <= rd_val;
               end
            end
            ADDR_LOW, WDATA_LOW: begin
               if (s_cs || !s_rd) begin
                  state <= IDLE;
               end else if (!s_wr) begin
                  if (cnt != 8'hFF) cnt <= cnt + 8'd1;
                  lat <= s_din;
               end else begin
                  if (cnt >= MIN_CNT) begin
                     if (state == ADDR_LOW) addr <= lat;
                     else wr_go <= 1'b1;
                  end
                  state <= IDLE;
               end
            end
            RDATA: begin
               if (!s_cs && !s_rd && s_wr && s_ad) begin
                  ADoe  <= 1'b1;
                  ADout <= rd_val;
               end else begin
                  ADoe  <= 1'b0;
                  ADout <= '0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign tick_now = (pre == PMAX);
   // A tick landing on a write commit is replayed next cycle so it applies to the new value.
   assign adv = (tick_now && !wr_go) || tick_defer;

   always_comb begin
      n_sec = sec; n_min = min; n_hr = hr; n_day = day; n_mon = mon; n_yr = yr;
      c_h = 1'b0; c_d = 1'b0; c_mo = 1'b0; c_y = 1'b0;
      h_inc = inc_bcd({3'b000, hr[4:0]});
      if (sec == 8'h59) begin
         n_sec = '0;
         if (min == 8'h59) begin n_min = '0; c_h = 1'b1; end
         else n_min = inc_bcd(min);
      end else begin
         n_sec = inc_bcd(sec);
      end
      if (c_h) begin
         if (ctrl[4]) begin
            if (hr[4:0] == 5'h11) begin
               n_hr = {hr[7:6], ~hr[5], 5'h12};
               c_d  = hr[5];
            end else if (hr[4:0] == 5'h12) begin
               n_hr = {hr[7:5], 5'h01};
            end else begin
               n_hr = {hr[7:5], h_inc[4:0]};
            end
         end else if (hr == 8'h23) begin
            n_hr = '0;
            c_d  = 1'b1;
         end else begin
            n_hr = inc_bcd(hr);
         end
      end
      if (c_d) begin
         if (day >= month_days(mon, yr)) begin n_day = 8'h01; c_mo = 1'b1; end
         else n_day = inc_bcd(day);
      end
      if (c_mo) begin
         if (mon >= 8'h12) begin n_mon = 8'h01; c_y = 1'b1; end
         else n_mon = inc_bcd(mon);
      end
      if (c_y) n_yr = (yr == 8'h99) ? 8'h00 : inc_bcd(yr);

      n_tsec = tsec; n_tmin = tmin; n_thr = thr;
      t_expire = 1'b0;
      if ({tsec, tmin, thr} == '0) begin
         t_expire = 1'b1;
      end else begin
         if (tsec != 8'h00) begin
            n_tsec = dec_bcd(tsec);
         end else begin
            n_tsec = 8'h59;
            if (tmin != 8'h00) n_tmin = dec_bcd(tmin);
            else begin n_tmin = 8'h59; n_thr = dec_bcd(thr); end
         end
         t_expire = ({n_tsec, n_tmin, n_thr} == '0);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pre <= '0; tick <= 1'b0; tick_defer <= 1'b0; irq_n <= 1'b1;
         ctrl <= '0; status <= '0; sec <= '0; min <= '0; hr <= '0;
         day <= 8'h01; mon <= 8'h01; yr <= '0; tsec <= '0; tmin <= '0; thr <= '0;
      end else begin
         pre        <= tick_now ? '0 : pre + 1'b1;
         tick       <= tick_now;
         tick_defer <= tick_now && wr_go;
         if (adv) begin
            sec <= n_sec; min <= n_min; hr <= n_hr; day <= n_day; mon <= n_mon; yr <= n_yr;
            if (ctrl[3]) begin
               tsec <= n_tsec; tmin <= n_tmin; thr <= n_thr;
               if (t_expire) begin
                  status[0] <= 1'b1;
                  irq_n     <= 1'b0;
                  ctrl[3]   <= 1'b0;
               end
            end
         end
         if (wr_go) begin
            case (addr)
               8'h00: ctrl <= lat;
               8'h01: begin status <= '0; irq_n <= 1'b1; end
               8'h21: sec  <= lat;
               8'h22: min  <= lat;
               8'h23: hr   <= lat;
               8'h24: day  <= lat;
               8'h25: mon  <= lat;
               8'h26: yr   <= lat;
               8'h41: tsec <= lat;
               8'h42: tmin <= lat;
               8'h43: thr  <= lat;
               default: ;
            endcase
         end
      end
   end
endmodule
